// File: rtl/que_wr_arbiter_if.sv
// Write-side bus between the producers, the arbiter and the buf_que write port.
interface que_wr_arbiter_if #(
  parameter int ID_BIT = 2,
  parameter int WIDTH  = 8
) ();
  localparam int NREQ = 1 << ID_BIT;

  logic [NREQ-1:0]       req;
  logic [NREQ-1:0]       lock;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       ack;
  logic                  que_write_flag;
  logic [WIDTH-1:0]      que_write_data;
  logic                  que_full;
  logic [ID_BIT-1:0]     grant_id;

  modport slave (
    input  req, lock, req_data, que_full,
    output ack, que_write_flag, que_write_data, grant_id
  );

  modport master (
    output req, lock, req_data, que_full,
    input  ack, que_write_flag, que_write_data, grant_id
  );
endinterface

// File: rtl/que_wr_arbiter.sv
// Round-robin arbiter sharing one buf_que write port between NREQ producers,
// with a single registered output stage and lock-based burst contiguity.
module que_wr_arbiter #(
  parameter int ID_BIT = 2,
  parameter int WIDTH  = 8
) (
  input logic              clk,
  input logic              rst,
  que_wr_arbiter_if.slave  bus
);
  localparam int NREQ = 1 << ID_BIT;

  typedef enum logic {ARB, LOCKED} state_t;

  state_t            state;
  logic              out_valid;
  logic [WIDTH-1:0]  out_data;
  logic [ID_BIT-1:0] grant_q;
  logic [ID_BIT-1:0] rr_ptr;
  logic [ID_BIT-1:0] owner;

  logic              can_take;
  logic              have_win;
  logic [ID_BIT-1:0] winner;
  logic [ID_BIT-1:0] idx;
  logic              take;
  logic [ID_BIT-1:0] sel;
  logic              sel_lock;
  logic [WIDTH-1:0]  sel_data;
  logic [NREQ-1:0]   ack_c;
  logic [WIDTH-1:0]  data_arr [NREQ];

  always_comb begin
    for (int unsigned k = 0; k < NREQ; k++) begin
      data_arr[k] = bus.req_data[k*WIDTH +: WIDTH];
    end
  end

  // Draining and accepting in the same edge keeps full one-beat-per-cycle throughput.
  always_comb begin
    can_take = !out_valid || !bus.que_full;
    have_win = 1'b0;
    winner   = '0;
    idx      = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = rr_ptr + ID_BIT'(k);
      if (!have_win && bus.req[idx]) begin
        have_win = 1'b1;
        winner   = idx;
      end
    end
  end

  always_comb begin
    take  = 1'b0;
    sel   = '0;
    ack_c = '0;
    if (state == LOCKED) begin
      sel  = owner;
      take = can_take && bus.req[owner];
    end else begin
      sel  = winner;
      take = can_take && have_win;
    end
    if (take && !rst) begin
      ack_c[sel] = 1'b1;
    end
    sel_lock = bus.lock[sel];
    sel_data = data_arr[sel];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ARB;
      out_valid <= 1'b0;
      out_data  <= '0;
      grant_q   <= '0;
      rr_ptr    <= '0;
      owner     <= '0;
    end else begin
      if (take) begin
        out_valid <= 1'b1;
        out_data  <= sel_data;
        grant_q   <= sel;
        if (sel_lock) begin
          state <= LOCKED;
          owner <= sel;
        end else begin
          state  <= ARB;
          rr_ptr <= sel + ID_BIT'(1);
        end
      end else if (out_valid && !bus.que_full) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign bus.ack            = ack_c;
  assign bus.que_write_flag = out_valid;
  assign bus.que_write_data = out_data;
  assign bus.grant_id       = grant_q;
endmodule

// File: tb/tb_que_wr_arbiter.sv
// Bench for que_wr_arbiter: directed scenarios then constrained-random traffic,
// all checked against a behavioural round-robin/lock model.
module tb_que_wr_arbiter;
  localparam int ID_BIT = 2;
  localparam int WIDTH  = 8;
  localparam int NREQ   = 1 << ID_BIT;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  que_wr_arbiter_if #(.ID_BIT(ID_BIT), .WIDTH(WIDTH)) bus ();
  que_wr_arbiter #(.ID_BIT(ID_BIT), .WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  bit               m_valid;
  logic [WIDTH-1:0] m_data;
  int               m_grant, m_ptr, m_owner;
  bit               m_locked;
  logic [NREQ-1:0]  exp_ack;
  int               e_sel;
  bit               e_take;

  logic [NREQ-1:0]  r_req, r_lock;
  logic [WIDTH-1:0] r_data [NREQ];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_data = '0; m_grant = 0; m_ptr = 0; m_owner = 0; m_locked = 0;
  endtask

  task automatic predict();
    bit ct;
    int c;
    ct = !m_valid || !bus.que_full;
    e_take = 0;
    e_sel  = 0;
    if (!rst && ct) begin
      if (m_locked) begin
        if (bus.req[m_owner]) begin e_take = 1; e_sel = m_owner; end
      end else begin
        for (int k = 0; k < NREQ; k++) begin
          c = (m_ptr + k) % NREQ;
          if (!e_take && bus.req[c]) begin e_take = 1; e_sel = c; end
        end
      end
    end
    exp_ack = '0;
    if (e_take) exp_ack[e_sel] = 1'b1;
  endtask

  // want: -2 = no directed ack check, -1 = no ack, else index expected acked
  task automatic step(input string tag, input int want);
    logic             lk;
    logic [WIDTH-1:0] d;
    logic [NREQ-1:0]  w;
    #1;
    predict();
    chk({tag, ".ack"}, 32'(bus.ack), 32'(exp_ack));
    if (want != -2) begin
      w = '0;
      if (want >= 0) w[want] = 1'b1;
      chk({tag, ".dir_ack"}, 32'(bus.ack), 32'(w));
    end
    lk = bus.lock[e_sel];
    d  = bus.req_data[e_sel*WIDTH +: WIDTH];
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else if (e_take) begin
      m_valid = 1; m_data = d; m_grant = e_sel;
      if (lk) begin m_locked = 1; m_owner = e_sel; end
      else begin m_locked = 0; m_ptr = (e_sel + 1) % NREQ; end
    end else if (m_valid && !bus.que_full) begin
      m_valid = 0;
    end
    #1;
    chk({tag, ".flag"},  32'(bus.que_write_flag), 32'(m_valid));
    chk({tag, ".data"},  32'(bus.que_write_data), 32'(m_data));
    chk({tag, ".grant"}, 32'(bus.grant_id), 32'(m_grant[ID_BIT-1:0]));
  endtask

  task automatic apply();
    bus.req  = r_req;
    bus.lock = r_lock;
    for (int i = 0; i < NREQ; i++) bus.req_data[i*WIDTH +: WIDTH] = r_data[i];
  endtask

  initial begin
    model_reset();
    bus.que_full = 1'b0;
    r_lock = '0;
    r_req  = '1;
    for (int i = 0; i < NREQ; i++) r_data[i] = WIDTH'(8'hA0 + i);
    apply();

    // Reset with all requests high
    rst = 1'b1;
    step("rst0", -1);
    step("rst1", -1);
    chk("rst.flag", 32'(bus.que_write_flag), 32'd0);
    chk("rst.grant", 32'(bus.grant_id), 32'd0);
    rst = 1'b0;

    // Round robin with all requesters active
    for (int k = 0; k < 6; k++) begin
      step("rr", k % NREQ);
      chk("rr.seq_data", 32'(bus.que_write_data), 32'(8'hA0 + (k % NREQ)));
    end
    // rr_ptr now 2 (requester 1 granted last)

    // Backpressure: load 0x55 from requester 0, then hold with que_full
    r_req = 4'b0001; r_data[0] = 8'h55; apply();
    step("bp_load", 0);
    r_req = 4'b0010; r_data[1] = 8'h66; apply();
    bus.que_full = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step("bp_hold", -1);
      chk("bp.hold_data", 32'(bus.que_write_data), 32'h55);
      chk("bp.hold_flag", 32'(bus.que_write_flag), 32'd1);
    end
    bus.que_full = 1'b0;
    step("bp_release", 1);
    chk("bp.new_data", 32'(bus.que_write_data), 32'h66);
    // rr_ptr now 2

    // Locked burst from requester 2 with 0 and 3 competing, gap inside burst
    r_req = 4'b1101; r_lock = 4'b0100;
    r_data[0] = 8'h10; r_data[2] = 8'h21; r_data[3] = 8'h30; apply();
    step("lk_b0", 2);
    r_data[2] = 8'h22; apply();
    step("lk_b1", 2);
    r_req = 4'b1001; apply();
    step("lk_gap0", -1);
    step("lk_gap1", -1);
    r_req = 4'b1101; r_lock = 4'b0000; r_data[2] = 8'h23; apply();
    step("lk_b2", 2);
    chk("lk.last_data", 32'(bus.que_write_data), 32'h23);
    step("lk_next3", 3);
    r_req = 4'b0001; apply();
    step("lk_next0", 0);

    // Wrap and skip: move rr_ptr to 3, then req 0101
    r_req = 4'b0100; apply();
    step("wr_set", 2);
    r_req = 4'b0101; apply();
    step("wr_a", 0);
    step("wr_b", 2);
    step("wr_c", 0);

    // Reset mid-burst
    r_req = 4'b0010; r_lock = 4'b0010; apply();
    step("rm_lock", 1);
    r_req = 4'b1111; apply();
    rst = 1'b1;
    step("rm_rst", -1);
    rst = 1'b0;
    r_req = 4'b0011; r_lock = 4'b0000; apply();
    step("rm_first", 0);

    // Random traffic honouring the hold-until-ack contract
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (r_req[i] && !exp_ack[i] && !rst) begin
          if ($urandom_range(7) == 0) r_req[i] = 1'b0;
        end else begin
          r_req[i]  = ($urandom_range(2) != 0);
          r_lock[i] = ($urandom_range(1) != 0);
          r_data[i] = WIDTH'($urandom);
        end
      end
      apply();
      bus.que_full = ($urandom_range(2) == 0);
      rst = ($urandom_range(59) == 0);
      step("rnd", -2);
    end
    rst = 1'b0;
    bus.que_full = 1'b0;
    r_req = '0; apply();
    step("drain0", -1);
    step("drain1", -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/que_wr_arbiter.md
# que_wr_arbiter

Round-robin write-side arbiter that shares one `buf_que` write port between `NREQ` producers, such as the UART TX path, the debug dump and the core store path. It picks one requester per cycle and registers that beat in a single output stage. It drives `write_flag`/`write_data` of the queue and honours `full` backpressure. A lock mechanism keeps multi-beat bursts from one requester contiguous in the queue.

## Interface
- `ID_BIT`, default 2: requester index width; `NREQ = 1<<ID_BIT`.
- `WIDTH`, default 8: data beat width; must match the queue's `WIDTH`.
- `clk`  in  1  clock; all state changes on posedge.
- `rst`  in  1  reset, synchronous, active-high.
- `req`  in  NREQ  per-requester beat valid; bit i = requester i.
- `lock`  in  NREQ  per-requester "more beats follow" flag; sampled only with the matching `req` bit.
- `req_data`  in  NREQ*WIDTH  beat data; requester i occupies bits [i*WIDTH +: WIDTH].
- `ack`  out  NREQ  combinational one-hot acceptance; bit i high means requester i's beat is taken at this edge.
- `que_write_flag`  out  1  to queue `write_flag`; equals output-stage valid.
- `que_write_data`  out  WIDTH  to queue `write_data`.
- `que_full`  in  1  from queue `full`.
- `grant_id`  out  ID_BIT  index of the requester whose beat sits in the output stage.

## Operation
- State: output stage (`out_valid`, `out_data`, `grant_id`), round-robin pointer `rr_ptr` (ID_BIT), FSM {ARB, LOCKED}, `owner` (ID_BIT).
- Stage drains at a posedge when `out_valid && !que_full`.
- The stage can accept a new beat when `!out_valid || !que_full`; call this `can_take`.
- ARB:
  - Winner is the first i with `req[i]=1`, scanning `rr_ptr, rr_ptr+1, …` modulo NREQ. Index arithmetic is ID_BIT wide and wraps naturally.
  - If `can_take` and a winner exists: `ack[winner]=1`; at the edge, the stage loads `req_data` of the winner and `grant_id<=winner`.
  - If the winner's `lock=1`: go to LOCKED, `owner<=winner`, `rr_ptr` unchanged.
  - Otherwise: `rr_ptr<=winner+1`.
- LOCKED:
  - Only `owner` is eligible. Other requests get no ack, however long they wait.
  - If `can_take && req[owner]`: ack owner and load its beat.
  - If that beat has `lock[owner]=0`: return to ARB and set `rr_ptr<=owner+1`.
  - If `req[owner]=0`: no grant; stay LOCKED (idle gap inside a burst is legal).
- `ack` is 0 for all bits whenever `can_take=0`. `ack` is at most one-hot.
- If the stage drains and a new beat is taken in the same edge, the new beat replaces the old one: full 1 beat/cycle throughput.
- The queue's `write_flag&&!full` gating matches the drain condition, so no beat is lost or duplicated.
- Requester contract: `req_data` and `lock` hold stable while `req=1 && ack=0`. A requester may drop `req` before ack without side effects.
- Reset, at the edge with `rst=1`:
  - `que_write_flag=0`, `que_write_data=0`, `grant_id=0`.
  - `rr_ptr=0`, FSM=ARB, `owner=0`.
  - `ack=0` while `rst=1`.
  - Reset mid-burst abandons the lock; beats already written to the queue stay there.

## Timing
- Latency: beat acked at edge N appears on `que_write_flag`/`que_write_data` during cycle N+1. The queue stores it at edge N+1 if `que_full=0`.
- `que_full=1`: stage holds data and `grant_id` unchanged, all `ack=0`, no pointer or FSM change.
- `que_full` falling: drain and new accept occur at the same edge.
- Same-cycle simultaneous requests: exactly one ack per cycle. The others keep `req` high and are served in later cycles.
- Wrap-around: `rr_ptr=NREQ-1` granting NREQ-1 yields `rr_ptr=0`.

## Test plan
- **Reset:** `rst=1` for 2 cycles with all `req=1` -> `ack=0`, `que_write_flag=0`, `grant_id=0`. After release with `req=4'b1111`, the first ack is bit 0 and flag rises the next cycle.
- **Round-robin, `req=4'b1111` held, `que_full=0`, data i=8'hA0+i:**
  - Acks go 0,1,2,3,0,… one per cycle.
  - `que_write_data` sequence: A0,A1,A2,A3,A0, each one cycle after its ack.
- **Backpressure:** stage holding 8'h55, `que_full=1` for 3 cycles with `req=4'b0010` -> flag stays 1, data stays 55, `ack=0`. Then `que_full=0` -> at that edge 55 drains and requester 1's beat loads with `ack[1]=1`.
- **Lock burst:**
  - Requester 2 sends 3 beats (`lock`=1,1,0) while `req[0]` and `req[3]` are also high. Acks go 2,2,2, then 3, then 0.
  - A 2-cycle `req[2]=0` gap inside the burst yields no acks to others.
- **Wrap and skip:** `rr_ptr=3` with `req=4'b0101` -> ack 0, then 2, then 0.
- **Reset mid-burst:** owner=1 in LOCKED, assert `rst` -> FSM=ARB and `rr_ptr=0`. With `req=4'b0011` after reset, the first ack is bit 0.
